// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, signed/unsigned; start accepted at edge k gives done after edge k+WIDTH+1.
// start is ignored while busy; flags/mult_out tri-state under oe without affecting sequencing.
module seq_multiplier #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   primary_operand,
  input  logic [WIDTH-1:0]   secondary_operand,
  input  logic               is_signed,
  input  logic               start,
  input  logic               oe,
  output logic               busy,
  output logic               done,
  output logic [2:0]         flags,
  output logic [2*WIDTH-1:0] mult_out
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               sign, mode;
  logic [2*WIDTH-1:0] prod;
  logic               prod_signed;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_shift;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     prod_top;
  logic [2:0]         flags_int;

  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  assign mag_a     = (is_signed && primary_operand[WIDTH-1])   ? -primary_operand   : primary_operand;
  assign mag_b     = (is_signed && secondary_operand[WIDTH-1]) ? -secondary_operand : secondary_operand;
  assign sum       = mplier[0] ? acc[2*WIDTH:WIDTH] + {1'b0, mcand} : acc[2*WIDTH:WIDTH];
  assign acc_shift = {1'b0, sum, acc[WIDTH-1:1]};
  assign prod_fix  = sign ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
      mode        <= 1'b0;
      prod        <= '0;
      prod_signed <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand  <= mag_a;
          mplier <= mag_b;
          sign   <= is_signed & (primary_operand[WIDTH-1] ^ secondary_operand[WIDTH-1]);
          mode   <= is_signed;
          acc    <= '0;
          cnt    <= CNT_W'(WIDTH);
          busy   <= 1'b1;
        end
        RUN: begin
          acc    <= acc_shift;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
        end
        FIX: begin
          prod        <= prod_fix;
          prod_signed <= mode;
          busy        <= 1'b0;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Signed overflow: the top WIDTH+1 bits must be pure sign extension.
  assign prod_top     = prod[2*WIDTH-1:WIDTH-1];
  assign flags_int[0] = ~|prod;
  assign flags_int[1] = prod_signed & prod[2*WIDTH-1];
  assign flags_int[2] = prod_signed ? ~((&prod_top) | ~(|prod_top)) : |prod[2*WIDTH-1:WIDTH];

  assign flags    = oe ? flags_int : 3'bzzz;
  assign mult_out = oe ? prod : {(2*WIDTH){1'bz}};

endmodule
